// File: rtl/tb_clk_sequencer.sv
// Derives the test clock tclk from clk: free-running (automatic) or an exact
// number of periods per step request (manual), with full-length phases always.
module tb_clk_sequencer #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             nEnable,
    input  logic             manual,
    input  logic [DIV_W-1:0] half_period,
    input  logic             step_valid,
    input  logic [CNT_W-1:0] step_count,
    output logic             step_ready,
    input  logic             abort,
    output logic             tclk,
    output logic             tclk_rise,
    output logic             manual_active,
    output logic [CNT_W-1:0] steps_left,
    output logic             busy,
    output logic             step_done
);

    // Handshake: a step request transfers on a rising clk edge where
    // step_valid && step_ready; step_ready never depends on step_valid.
    typedef enum logic [1:0] {ST_STOPPED, ST_AUTO, ST_STEP} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_tclk, w_tclk_nxt;
    logic             r_rise, w_rise_nxt;
    logic             r_manual_active, w_manual_active_nxt;
    logic [CNT_W-1:0] r_steps_left, w_steps_left_nxt;
    logic             r_step_done, w_step_done_nxt;
    logic             r_stop_req, w_stop_req_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] w_h_m1;
    logic             w_phase_end;
    logic             w_step_ready;

    // Reload value H-1 with a zero half-period treated as one.
    assign w_h_m1       = (half_period == '0) ? '0 : half_period - DIV_W'(1);
    assign w_phase_end  = (r_cnt == '0);
    assign w_step_ready = (r_state == ST_STOPPED) && !nEnable && r_manual_active;

    always_comb begin
        w_state_nxt         = r_state;
        w_tclk_nxt          = r_tclk;
        w_rise_nxt          = 1'b0;
        w_manual_active_nxt = r_manual_active;
        w_steps_left_nxt    = r_steps_left;
        w_step_done_nxt     = 1'b0;
        w_stop_req_nxt      = r_stop_req;
        w_cnt_nxt           = (r_cnt != '0) ? r_cnt - DIV_W'(1) : r_cnt;

        case (r_state)
            ST_STOPPED: begin
                w_tclk_nxt          = 1'b0;
                w_manual_active_nxt = manual;
                w_stop_req_nxt      = 1'b0;
                if (w_step_ready && step_valid) begin
                    if (step_count != '0) begin
                        w_state_nxt         = ST_STEP;
                        w_steps_left_nxt    = step_count;
                        w_tclk_nxt          = 1'b1;
                        w_rise_nxt          = 1'b1;
                        w_cnt_nxt           = w_h_m1;
                        w_manual_active_nxt = 1'b1;
                    end else begin
                        w_step_done_nxt = 1'b1;
                    end
                end else if (!nEnable && !r_manual_active) begin
                    w_state_nxt         = ST_AUTO;
                    w_tclk_nxt          = 1'b1;
                    w_rise_nxt          = 1'b1;
                    w_cnt_nxt           = w_h_m1;
                    w_manual_active_nxt = 1'b0;
                end
            end
            ST_AUTO: begin
                if (w_phase_end) begin
                    if (r_tclk) begin
                        w_tclk_nxt = 1'b0;
                        w_cnt_nxt  = w_h_m1;
                    end else if (nEnable || manual) begin
                        // Stopping only after a full low phase keeps tclk glitch-free.
                        w_state_nxt         = ST_STOPPED;
                        w_manual_active_nxt = manual;
                    end else begin
                        w_tclk_nxt = 1'b1;
                        w_rise_nxt = 1'b1;
                        w_cnt_nxt  = w_h_m1;
                    end
                end
            end
            ST_STEP: begin
                w_stop_req_nxt = r_stop_req || abort || nEnable;
                if (w_phase_end) begin
                    if (r_tclk) begin
                        w_tclk_nxt = 1'b0;
                        w_cnt_nxt  = w_h_m1;
                        if (r_steps_left != '0) w_steps_left_nxt = r_steps_left - CNT_W'(1);
                    end else if (r_steps_left == '0 || w_stop_req_nxt) begin
                        w_state_nxt      = ST_STOPPED;
                        w_steps_left_nxt = '0;
                        w_step_done_nxt  = 1'b1;
                        w_stop_req_nxt   = 1'b0;
                    end else begin
                        w_tclk_nxt     = 1'b1;
                        w_rise_nxt     = 1'b1;
                        w_cnt_nxt      = w_h_m1;
                        w_stop_req_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_STOPPED;
                w_tclk_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state         <= ST_STOPPED;
            r_tclk          <= 1'b0;
            r_rise          <= 1'b0;
            r_manual_active <= 1'b1;
            r_steps_left    <= '0;
            r_step_done     <= 1'b0;
            r_stop_req      <= 1'b0;
            r_cnt           <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_tclk          <= w_tclk_nxt;
            r_rise          <= w_rise_nxt;
            r_manual_active <= w_manual_active_nxt;
            r_steps_left    <= w_steps_left_nxt;
            r_step_done     <= w_step_done_nxt;
            r_stop_req      <= w_stop_req_nxt;
            r_cnt           <= w_cnt_nxt;
        end
    end

    assign tclk          = r_tclk;
    assign tclk_rise     = r_rise;
    assign manual_active = r_manual_active;
    assign steps_left    = r_steps_left;
    assign busy          = (r_state != ST_STOPPED);
    assign step_done     = r_step_done;
    assign step_ready    = w_step_ready;

endmodule

// File: tb/tb_tb_clk_sequencer.sv
// Directed bench for tb_clk_sequencer: reset, automatic mode, manual steps,
// abort, mode change and zero-count / zero-half-period corner cases.
module tb_tb_clk_sequencer;

    logic        clk = 1'b0;
    logic        nReset;
    logic        nEnable;
    logic        manual;
    logic [7:0]  half_period;
    logic        step_valid;
    logic [15:0] step_count;
    logic        step_ready;
    logic        abort;
    logic        tclk;
    logic        tclk_rise;
    logic        manual_active;
    logic [15:0] steps_left;
    logic        busy;
    logic        step_done;

    int n_checks = 0;
    int n_fail   = 0;

    tb_clk_sequencer #(.DIV_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .nReset       (nReset),
        .nEnable      (nEnable),
        .manual       (manual),
        .half_period  (half_period),
        .step_valid   (step_valid),
        .step_count   (step_count),
        .step_ready   (step_ready),
        .abort        (abort),
        .tclk         (tclk),
        .tclk_rise    (tclk_rise),
        .manual_active(manual_active),
        .steps_left   (steps_left),
        .busy         (busy),
        .step_done    (step_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Samples once per negedge for ncyc cycles starting with the current sample.
    task automatic monitor(input int ncyc, input int min_h, input int exp_start,
                           input int abort_at, input logic prev0,
                           output int rises, output int falls, output int last_fall,
                           output int done_at, output int last_busy);
        logic prev;
        int   run_start;
        bit   first_run;
        int   dones;
        prev = prev0; run_start = 0; first_run = 1; dones = 0;
        rises = 0; falls = 0; last_fall = -1; done_at = -1; last_busy = -1;
        for (int i = 0; i < ncyc; i++) begin
            check_eq("rise_pulse", tclk_rise, tclk && !prev);
            if (tclk_rise) rises++;
            if (i > 0 && tclk != prev) begin
                if (!first_run) check_eq("phase_len_ok", (i - run_start) >= min_h, 1);
                first_run = 0;
                run_start = i;
            end
            if (!tclk && prev) begin
                falls++;
                last_fall = i;
                if (exp_start >= 0) check_eq("steps_at_fall", steps_left, exp_start - falls);
            end
            if (step_done) begin
                dones++;
                done_at = i;
            end
            if (busy) last_busy = i;
            prev  = tclk;
            abort = (i == abort_at);
            @(negedge clk);
        end
        abort = 1'b0;
        check_eq("done_pulses", dones, (exp_start >= 0) ? 1 : 0);
    endtask

    task automatic wait_rise(input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (tclk_rise) got = 1;
        end
        check_eq(tag, got, 1);
    endtask

    int rises, falls, last_fall, done_at, last_busy;
    logic exp_t;

    initial begin
        nReset = 1'b0; nEnable = 1'b1; manual = 1'b1; half_period = 8'd3;
        step_valid = 1'b0; step_count = '0; abort = 1'b0;

        // 1: reset values
        repeat (3) @(negedge clk);
        check_eq("rst_tclk", tclk, 0);
        check_eq("rst_rise", tclk_rise, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_manual_active", manual_active, 1);
        check_eq("rst_steps_left", steps_left, 0);
        check_eq("rst_step_done", step_done, 0);
        nReset = 1'b1;
        @(negedge clk);
        check_eq("idle_step_ready", step_ready, 0);
        check_eq("idle_manual_active", manual_active, 1);

        // 2: automatic mode H=3, then H=5 mid high phase
        manual = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("auto_manual_active", manual_active, 0);
        check_eq("auto_idle_busy", busy, 0);
        nEnable = 1'b0;
        @(negedge clk);
        check_eq("auto_first_rise", tclk_rise, 1);
        for (int k = 0; k <= 22; k++) begin
            if (k < 12)      exp_t = ((k / 3) % 2) == 0;
            else if (k < 15) exp_t = 1'b1;
            else if (k < 20) exp_t = 1'b0;
            else             exp_t = 1'b1;
            check_eq("auto_tclk", tclk, exp_t);
            check_eq("auto_rise", tclk_rise, (k == 0 || k == 6 || k == 12 || k == 20) ? 1 : 0);
            if (k == 12) half_period = 8'd5;
            if (k != 22) @(negedge clk);
        end
        // reset while tclk is high drops it at once
        nReset = 1'b0;
        #1;
        check_eq("async_rst_tclk", tclk, 0);
        check_eq("async_rst_busy", busy, 0);
        @(negedge clk);
        nEnable = 1'b1; manual = 1'b1; half_period = 8'd3;
        nReset = 1'b1;
        @(negedge clk);

        // 3: four manual steps with H=3
        nEnable = 1'b0;
        @(negedge clk);
        check_eq("step_ready_idle", step_ready, 1);
        step_valid = 1'b1; step_count = 16'd4;
        @(negedge clk);
        step_valid = 1'b0;
        check_eq("step_accept_left", steps_left, 4);
        check_eq("step_accept_busy", busy, 1);
        check_eq("step_accept_ready", step_ready, 0);
        monitor(40, 3, 4, -1, 1'b0, rises, falls, last_fall, done_at, last_busy);
        check_eq("step4_rises", rises, 4);
        check_eq("step4_falls", falls, 4);
        check_eq("step4_done_lat", done_at - last_fall, 3);
        check_eq("step4_end_tclk", tclk, 0);
        check_eq("step4_end_ready", step_ready, 1);
        check_eq("step4_end_left", steps_left, 0);
        check_eq("step4_end_busy", busy, 0);

        // 4: automatic H=4, manual requested during a high phase
        manual = 1'b0; half_period = 8'd4;
        wait_rise("auto4_start");
        manual = 1'b1;
        monitor(30, 4, -1, -1, 1'b0, rises, falls, last_fall, done_at, last_busy);
        check_eq("auto4_rises", rises, 1);
        check_eq("auto4_high_len", last_fall, 4);
        check_eq("auto4_last_busy", last_busy, 7);
        check_eq("auto4_manual_active", manual_active, 1);
        check_eq("auto4_tclk", tclk, 0);

        // 5: ten steps with H=2, abort during the third high phase
        half_period = 8'd2;
        step_valid = 1'b1; step_count = 16'd10;
        @(negedge clk);
        step_valid = 1'b0;
        check_eq("abort_accept_left", steps_left, 10);
        monitor(30, 2, 10, 8, 1'b0, rises, falls, last_fall, done_at, last_busy);
        check_eq("abort_rises", rises, 3);
        check_eq("abort_falls", falls, 3);
        check_eq("abort_done_lat", done_at - last_fall, 2);
        check_eq("abort_left", steps_left, 0);
        check_eq("abort_busy", busy, 0);

        // 6: zero-count request, request while disabled, zero half-period
        step_valid = 1'b1; step_count = 16'd0;
        @(negedge clk);
        step_valid = 1'b0;
        check_eq("zero_done", step_done, 1);
        check_eq("zero_tclk", tclk, 0);
        check_eq("zero_busy", busy, 0);
        @(negedge clk);
        check_eq("zero_done_clear", step_done, 0);
        nEnable = 1'b1; step_valid = 1'b1; step_count = 16'd3;
        @(negedge clk);
        step_valid = 1'b0;
        check_eq("disabled_ready", step_ready, 0);
        check_eq("disabled_busy", busy, 0);
        check_eq("disabled_tclk", tclk, 0);
        half_period = 8'd0; manual = 1'b0; nEnable = 1'b0;
        wait_rise("hp0_start");
        for (int k = 0; k < 8; k++) begin
            check_eq("hp0_tclk", tclk, (k % 2) == 0);
            check_eq("hp0_rise", tclk_rise, (k % 2) == 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
